// File: rtl/vrf_read_port_seq_pkg.sv
// Shared widths, element record and sequencer state encoding for the VRF read-port sequencer.
// Width helpers are constant functions so they can size ports and localparams.
package vrf_pkg;

   function automatic int log2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int bitwidth(input int n);
      return (log2(n) < 1) ? 1 : log2(n);
   endfunction

   localparam int VRF_MVL            = 32;
   localparam int VRF_NUM_REGS       = 32;
   localparam int VRF_DATA_WIDTH     = 32;
   localparam int VRF_VALID          = 1;
   localparam int VRF_NUM_READ_PORTS = 4;
   localparam int VRF_FIFO_DEPTH     = 4;
   localparam int VRF_SLICE_W        = VRF_DATA_WIDTH + VRF_VALID;
   localparam int VRF_RD_W           = VRF_NUM_REGS * VRF_NUM_READ_PORTS * VRF_SLICE_W;
   localparam int VRF_IDX_W          = bitwidth(VRF_MVL);
   localparam int VRF_VL_W           = VRF_IDX_W + 1;

   typedef struct packed {
      logic [VRF_DATA_WIDTH-1:0] data;
      logic [VRF_IDX_W-1:0]      idx;
      logic                      last;
   } elem_t;

   typedef enum logic [1:0] {
      RD_IDLE      = 2'd0,
      RD_WAIT_FREE = 2'd1,
      RD_STREAM    = 2'd2,
      RD_DRAIN     = 2'd3
   } rd_state_e;

endpackage

// File: rtl/vrf_read_port_seq_fifo.sv
// Element buffer: DEPTH-entry FIFO (power of 2), data visible the cycle after push.
// Push+pop on a full FIFO is allowed; a lone push to a full FIFO is dropped and flagged.
module vrf_elem_fifo
   import vrf_pkg::*;
#(
   parameter int DEPTH = VRF_FIFO_DEPTH,
   parameter int WIDTH = VRF_DATA_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_dat,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_dat,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [bitwidth(DEPTH):0] o_count
);

   localparam int AW = bitwidth(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_dat     = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_dat;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(i_push && o_full && !i_pop));

endmodule

// File: rtl/vrf_read_port_seq.sv
// Streams one vector register from bank read port PORT_ID to a lane; optional chaining via VRF_RD_CHAIN_EN.
// First element valid 2 cycles after r_signal_o; lane backpressure throttles r_signal_o through FIFO credits.
module vrf_read_port_seq
   import vrf_pkg::*;
#(
   parameter int MVL            = VRF_MVL,
   parameter int NUM_REGS       = VRF_NUM_REGS,
   parameter int DATA_WIDTH     = VRF_DATA_WIDTH,
   parameter int VALID          = VRF_VALID,
   parameter int NUM_READ_PORTS = VRF_NUM_READ_PORTS,
   parameter int PORT_ID        = 0,
   parameter int FIFO_DEPTH     = VRF_FIFO_DEPTH
) (
   input  logic                                                 clk,
   input  logic                                                 rst,
   input  logic                                                 req_valid_i,
   output logic                                                 req_ready_o,
   input  logic [bitwidth(NUM_REGS)-1:0]                        req_vreg_i,
   input  logic [bitwidth(MVL):0]                               req_vl_i,
   output logic [NUM_REGS-1:0]                                  r_signal_o,
   input  logic [NUM_REGS*NUM_READ_PORTS*(DATA_WIDTH+VALID)-1:0] rd_i,
   input  logic [NUM_REGS*NUM_READ_PORTS-1:0]                   busy_read_i,
`ifdef VRF_RD_CHAIN_EN
   input  logic [NUM_REGS-1:0]                                  first_elem_i,
`endif
   output logic                                                 elem_valid_o,
   input  logic                                                 elem_ready_i,
   output logic [DATA_WIDTH-1:0]                                elem_data_o,
   output logic [bitwidth(MVL)-1:0]                             elem_idx_o,
   output logic                                                 elem_last_o,
   output logic                                                 done_o
);

   localparam int SLICE_W = DATA_WIDTH + VALID;
   localparam int VREG_W  = bitwidth(NUM_REGS);
   localparam int IDX_W   = bitwidth(MVL);
   localparam int VL_W    = IDX_W + 1;
   localparam int CNT_W   = bitwidth(FIFO_DEPTH) + 1;

   rd_state_e         r_state;
   logic [VREG_W-1:0] r_vreg;
   logic [VL_W-1:0]   r_vl;
   logic [VL_W-1:0]   r_rcv_cnt;
   logic [IDX_W-1:0]  r_pop_cnt;
   logic              r_done;

   logic [SLICE_W-1:0]    w_slice [NUM_REGS];
   logic [NUM_REGS-1:0]   w_busy;
   logic [SLICE_W-1:0]    w_sel;
   logic [VL_W-1:0]       w_vl_eff;
   logic                  w_accept;
   logic                  w_push;
   logic                  w_last_push;
   logic                  w_rd_en;
   logic                  w_pop;
   logic                  w_chain_ok;
   logic [DATA_WIDTH-1:0] w_head;
   logic                  w_full;
   logic                  w_empty;
   logic [CNT_W-1:0]      w_count;
   logic                  w_unused;

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         w_slice[r] = rd_i[(r*NUM_READ_PORTS+PORT_ID)*SLICE_W +: SLICE_W];
         w_busy[r]  = busy_read_i[r*NUM_READ_PORTS+PORT_ID];
      end
   end

`ifdef VRF_RD_CHAIN_EN
   assign w_chain_ok = first_elem_i[r_vreg];
`else
   assign w_chain_ok = 1'b1;
`endif

   assign w_sel       = w_slice[r_vreg];
   assign w_vl_eff    = (req_vl_i > VL_W'(MVL)) ? VL_W'(MVL) : req_vl_i;
   assign req_ready_o = (r_state == RD_IDLE) && !r_done;
   assign w_accept    = req_valid_i && req_ready_o;
   assign w_push      = (r_state == RD_STREAM) && w_sel[DATA_WIDTH] && (r_rcv_cnt < r_vl);
   assign w_last_push = w_push && ((r_rcv_cnt + VL_W'(1)) == r_vl);
   // Two free slots: one for the element already in flight from last cycle's read, one for this read.
   assign w_rd_en     = (r_state == RD_STREAM) && (w_count <= CNT_W'(FIFO_DEPTH-2)) && !w_last_push;
   assign r_signal_o  = w_rd_en ? (NUM_REGS'(1) << r_vreg) : '0;

   assign w_pop        = !w_empty && elem_ready_i;
   assign elem_valid_o = !w_empty;
   assign elem_data_o  = w_empty ? '0 : w_head;
   assign elem_idx_o   = w_empty ? '0 : r_pop_cnt;
   assign elem_last_o  = !w_empty && ({1'b0, r_pop_cnt} == (r_vl - VL_W'(1)));
   assign done_o       = r_done;
   assign w_unused     = ^{rd_i, busy_read_i, w_full};

   vrf_elem_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_dat   (w_sel[DATA_WIDTH-1:0]),
      .i_pop   (w_pop),
      .o_dat   (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= RD_IDLE;
         r_vreg    <= '0;
         r_vl      <= '0;
         r_rcv_cnt <= '0;
         r_pop_cnt <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_pop) r_pop_cnt <= r_pop_cnt + IDX_W'(1);
         case (r_state)
            RD_IDLE: begin
               if (w_accept) begin
                  r_vreg    <= req_vreg_i;
                  r_vl      <= w_vl_eff;
                  r_rcv_cnt <= '0;
                  r_pop_cnt <= '0;
                  if (w_vl_eff == '0) r_done  <= 1'b1;
                  else                r_state <= RD_WAIT_FREE;
               end
            end
            RD_WAIT_FREE: begin
               if (!w_busy[r_vreg] && w_chain_ok) r_state <= RD_STREAM;
            end
            RD_STREAM: begin
               if (w_push)      r_rcv_cnt <= r_rcv_cnt + VL_W'(1);
               if (w_last_push) r_state   <= RD_DRAIN;
            end
            RD_DRAIN: begin
               if (w_empty && !w_push) begin
                  r_done  <= 1'b1;
                  r_state <= RD_IDLE;
               end
            end
            default: r_state <= RD_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vrf_read_port_seq.sv
// Bench for vrf_read_port_seq: reactive bank model plus an element scoreboard.
module tb_vrf_read_port_seq;
   import vrf_pkg::*;

   localparam int NREG  = 32;
   localparam int NRP   = 4;
   localparam int DW    = 32;
   localparam int SW    = DW + 1;
   localparam int MVL   = 32;
   localparam int DEPTH = 4;
   localparam int RD_W  = NREG * NRP * SW;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            req_valid_i = 1'b0;
   logic            req_ready_o;
   logic [4:0]      req_vreg_i = '0;
   logic [5:0]      req_vl_i = '0;
   logic [NREG-1:0] r_signal_o;
   logic [RD_W-1:0] rd_i = '0;
   logic [NREG*NRP-1:0] busy_read_i = '0;
`ifdef VRF_RD_CHAIN_EN
   logic [NREG-1:0] first_elem_i = '1;
`endif
   logic            elem_valid_o;
   logic            elem_ready_i = 1'b0;
   logic [DW-1:0]   elem_data_o;
   logic [4:0]      elem_idx_o;
   logic            elem_last_o;
   logic            done_o;

   always #5 clk = ~clk;

   vrf_read_port_seq #(
      .MVL(MVL), .NUM_REGS(NREG), .DATA_WIDTH(DW), .VALID(1),
      .NUM_READ_PORTS(NRP), .PORT_ID(0), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_vreg_i(req_vreg_i), .req_vl_i(req_vl_i),
      .r_signal_o(r_signal_o), .rd_i(rd_i), .busy_read_i(busy_read_i),
`ifdef VRF_RD_CHAIN_EN
      .first_elem_i(first_elem_i),
`endif
      .elem_valid_o(elem_valid_o), .elem_ready_i(elem_ready_i),
      .elem_data_o(elem_data_o), .elem_idx_o(elem_idx_o),
      .elem_last_o(elem_last_o), .done_o(done_o)
   );

   logic [7:0] salt;
   int cyc = 0;
   int bank_ptr = 0;
   int n_vec = 0;
   int n_err = 0;
   int done_cnt, pops, rsig_cycles, first_rsig, first_valid, first_pop, last_pop;
   elem_t exp_q[$];
   elem_t m_e;
   logic prev_stall = 1'b0;
   logic [DW-1:0] prev_dat;
   logic [4:0] prev_idx;
   logic prev_last;

   function automatic logic [31:0] mkdat(input int r, input int i);
      return {r[7:0], salt, i[15:0]};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Bank: one-cycle read latency on port 0; port 1 always shows valid decoy data.
   always @(posedge clk) begin : bank
      logic [RD_W-1:0] t;
      t = '0;
      for (int r = 0; r < NREG; r++) begin
         t[(r*NRP+1)*SW +: SW] = {1'b1, 32'hDEAD0000 | 32'(r)};
         if (r_signal_o[r]) t[(r*NRP)*SW +: SW] = {1'b1, mkdat(r, bank_ptr)};
      end
      rd_i <= t;
      if (req_valid_i && req_ready_o) bank_ptr <= 0;
      else if (|r_signal_o)           bank_ptr <= bank_ptr + 1;
   end

   always @(negedge clk) begin
      if (rst) begin
         if (r_signal_o != '0) begin
            rsig_cycles++;
            if (first_rsig < 0) first_rsig = cyc;
         end
         if (elem_valid_o && first_valid < 0) first_valid = cyc;
         if (done_o) done_cnt++;
         if (prev_stall && elem_valid_o) begin
            n_vec++;
            if ({elem_data_o, elem_idx_o, elem_last_o} !== {prev_dat, prev_idx, prev_last}) begin
               n_err++;
               $display("FAIL stall_stable: got %h/%0d/%b want %h/%0d/%b", elem_data_o, elem_idx_o, elem_last_o, prev_dat, prev_idx, prev_last);
            end
         end
         if (elem_valid_o && elem_ready_i) begin
            pops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL sb_extra: got %h idx %0d, want nothing", elem_data_o, elem_idx_o);
            end else begin
               m_e = exp_q.pop_front();
               if (elem_data_o !== m_e.data || elem_idx_o !== m_e.idx || elem_last_o !== m_e.last) begin
                  n_err++;
                  $display("FAIL sb_elem: got %h/%0d/%b want %h/%0d/%b", elem_data_o, elem_idx_o, elem_last_o, m_e.data, m_e.idx, m_e.last);
               end
            end
         end
         prev_stall = elem_valid_o && !elem_ready_i;
         prev_dat   = elem_data_o;
         prev_idx   = elem_idx_o;
         prev_last  = elem_last_o;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic clr_stats();
      done_cnt = 0; pops = 0; rsig_cycles = 0;
      first_rsig = -1; first_valid = -1; first_pop = -1; last_pop = -1;
   endtask

   task automatic issue_req(input int vreg, input int vl, output int acc_cyc);
      int veff;
      elem_t e;
      veff = (vl > MVL) ? MVL : vl;
      req_vreg_i = 5'(vreg);
      req_vl_i = 6'(vl);
      req_valid_i = 1'b1;
      acc_cyc = -1;
      for (int k = 0; k < 100; k++) begin
         automatic logic a = req_ready_o;
         @(posedge clk); #1;
         if (a) begin acc_cyc = cyc; break; end
      end
      req_valid_i = 1'b0;
      n_vec++;
      if (acc_cyc < 0) begin
         n_err++;
         $display("FAIL req_accept: vreg %0d never accepted, want accept within 100 cycles", vreg);
      end else begin
         for (int i = 0; i < veff; i++) begin
            e.data = mkdat(vreg, i);
            e.idx  = 5'(i);
            e.last = (i == veff - 1);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic wait_done(input int budget, input bit rnd_ready, output int dcyc);
      dcyc = -1;
      for (int k = 0; k < budget; k++) begin
         if (rnd_ready) elem_ready_i = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         if (done_o) begin dcyc = cyc; break; end
      end
      if (rnd_ready) elem_ready_i = 1'b1;
      n_vec++;
      if (dcyc < 0) begin
         n_err++;
         $display("FAIL done_timeout: no done_o within %0d cycles", budget);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      elem_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %b want 1", req_ready_o); end
      n_vec++; if (r_signal_o !== '0) begin n_err++; $display("FAIL rst_r_signal: got %h want 0", r_signal_o); end
      n_vec++; if (elem_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_elem_valid: got %b want 0", elem_valid_o); end
      n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done_o); end
      n_vec++; if ({elem_data_o, elem_idx_o, elem_last_o} !== '0) begin n_err++; $display("FAIL rst_elem_fields: got %h/%0d/%b want 0", elem_data_o, elem_idx_o, elem_last_o); end
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int a, d;
      clr_stats();
      elem_ready_i = 1'b1;
      issue_req(5, 4, a);
      wait_done(200, 1'b0, d);
      @(posedge clk); #1;
      n_vec++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL basic_ready_after_done: got %b want 1", req_ready_o); end
      n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
      n_vec++; if (pops != 4) begin n_err++; $display("FAIL basic_pops: got %0d want 4", pops); end
      n_vec++; if (first_valid - first_rsig != 2) begin n_err++; $display("FAIL basic_latency: got %0d want 2", first_valid - first_rsig); end
      n_vec++; if (last_pop - first_pop != 3) begin n_err++; $display("FAIL basic_consecutive: got span %0d want 3", last_pop - first_pop); end
      n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL basic_sb_left: got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_vl_zero();
      int a;
      clr_stats();
      issue_req(11, 0, a);
      n_vec++; if (done_o !== 1'b1) begin n_err++; $display("FAIL vl0_done: got %b want 1", done_o); end
      @(posedge clk); #1;
      n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL vl0_done_pulse: got %b want 0", done_o); end
      n_vec++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL vl0_ready: got %b want 1", req_ready_o); end
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (rsig_cycles != 0) begin n_err++; $display("FAIL vl0_no_read: got %0d r_signal cycles want 0", rsig_cycles); end
      n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL vl0_done_count: got %0d want 1", done_cnt); end
   endtask

   task automatic test_clamp();
      int a, d;
      clr_stats();
      elem_ready_i = 1'b1;
      issue_req(7, 40, a);
      wait_done(400, 1'b0, d);
      @(posedge clk); #1;
      n_vec++; if (pops != 32) begin n_err++; $display("FAIL clamp_pops: got %0d want 32", pops); end
      n_vec++; if (last_pop - first_pop != 31) begin n_err++; $display("FAIL clamp_throughput: got span %0d want 31", last_pop - first_pop); end
      n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL clamp_sb_left: got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_backpressure();
      int a, d;
      clr_stats();
      elem_ready_i = 1'b0;
      issue_req(9, 16, a);
      repeat (10) @(posedge clk);
      #1;
      n_vec++; if (rsig_cycles != DEPTH) begin n_err++; $display("FAIL bp_reads_issued: got %0d want %0d", rsig_cycles, DEPTH); end
      n_vec++; if (r_signal_o !== '0) begin n_err++; $display("FAIL bp_r_signal_off: got %h want 0", r_signal_o); end
      n_vec++; if (elem_valid_o !== 1'b1) begin n_err++; $display("FAIL bp_valid_held: got %b want 1", elem_valid_o); end
      elem_ready_i = 1'b1;
      wait_done(300, 1'b0, d);
      @(posedge clk); #1;
      n_vec++; if (pops != 16) begin n_err++; $display("FAIL bp_pops: got %0d want 16", pops); end
      n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_sb_left: got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_busy();
      int a, d;
      clr_stats();
      elem_ready_i = 1'b1;
      busy_read_i[3*NRP] = 1'b1;
      busy_read_i[4*NRP] = 1'b1;
`ifdef VRF_RD_CHAIN_EN
      first_elem_i[3] = 1'b0;
`endif
      issue_req(3, 6, a);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         n_vec++; if (r_signal_o !== '0) begin n_err++; $display("FAIL busy_hold_%0d: got %h want 0", k, r_signal_o); end
      end
      busy_read_i[3*NRP] = 1'b0;
`ifdef VRF_RD_CHAIN_EN
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         n_vec++; if (r_signal_o !== '0) begin n_err++; $display("FAIL chain_hold_%0d: got %h want 0", k, r_signal_o); end
      end
      first_elem_i[3] = 1'b1;
`endif
      @(posedge clk); #1;
      n_vec++; if (r_signal_o !== 32'h8) begin n_err++; $display("FAIL busy_release: got %h want 00000008", r_signal_o); end
      busy_read_i[4*NRP] = 1'b0;
      wait_done(200, 1'b0, d);
      @(posedge clk); #1;
      n_vec++; if (pops != 6) begin n_err++; $display("FAIL busy_pops: got %0d want 6", pops); end
   endtask

   task automatic test_back_to_back();
      int vregs[4] = '{1, 2, 6, 10};
      int vls[4]   = '{3, 0, 5, 1};
      int a, d, prev_d;
      clr_stats();
      prev_d = -1;
      for (int i = 0; i < 4; i++) begin
         issue_req(vregs[i], vls[i], a);
         if (prev_d >= 0) begin
            n_vec++;
            if (a != prev_d + 2) begin n_err++; $display("FAIL b2b_accept_%0d: got cycle %0d want %0d", i, a, prev_d + 2); end
         end
         if (vls[i] == 0) begin
            d = a;
            n_vec++; if (done_o !== 1'b1) begin n_err++; $display("FAIL b2b_vl0_done: got %b want 1", done_o); end
         end else begin
            wait_done(300, 1'b1, d);
         end
         prev_d = d;
      end
      @(posedge clk); #1;
      n_vec++; if (pops != 9) begin n_err++; $display("FAIL b2b_pops: got %0d want 9", pops); end
      n_vec++; if (done_cnt != 4) begin n_err++; $display("FAIL b2b_done_count: got %0d want 4", done_cnt); end
      n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_sb_left: got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_reset_midstream();
      int a;
      bit seen;
      clr_stats();
      elem_ready_i = 1'b0;
      issue_req(2, 8, a);
      seen = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk); #1;
         if (elem_valid_o && r_signal_o == '0) begin seen = 1'b1; break; end
      end
      n_vec++; if (!seen) begin n_err++; $display("FAIL mid_reach_stream: got no filled FIFO want stall mid-stream"); end
      rst = 1'b0;
      @(posedge clk); #1;
      n_vec++; if (r_signal_o !== '0) begin n_err++; $display("FAIL mid_rst_r_signal: got %h want 0", r_signal_o); end
      n_vec++; if (elem_valid_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", elem_valid_o); end
      n_vec++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready: got %b want 1", req_ready_o); end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      elem_ready_i = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      n_vec++; if (done_cnt != 0) begin n_err++; $display("FAIL mid_no_done: got %0d pulses want 0", done_cnt); end
      n_vec++; if (pops != 0) begin n_err++; $display("FAIL mid_no_elems: got %0d want 0", pops); end
   endtask

   initial begin
      salt = 8'($urandom);
      busy_read_i[3*NRP+1] = 1'b1;
      clr_stats();
      test_reset();
      test_basic();
      test_vl_zero();
      test_clamp();
      test_backpressure();
      test_busy();
      test_back_to_back();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded 30000 cycles");
      $fatal(1);
   end

endmodule
